// File: rtl/pyon_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pyon_pkg : shared types and constants for the race-game referees          |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
package pyon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PLAY    = 2'd1,
    ST_PENALTY = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  localparam logic [1:0] WIN_NONE   = 2'b00;
  localparam logic [1:0] WIN_PLAYER = 2'b01;
  localparam logic [1:0] WIN_PC     = 2'b10;

  localparam int DEF_START_TENS = 3;
  localparam int DEF_START_ONES = 2;

  // Two-digit BCD decrement that saturates at 00.
  function automatic logic [7:0] bcd_dec(input logic [7:0] s);
    logic [7:0] r;
    r = s;
    if (s[3:0] != 4'd0) begin
      r[3:0] = s[3:0] - 4'd1;
    end else if (s[7:4] != 4'd0) begin
      r[3:0] = 4'd9;
      r[7:4] = s[7:4] - 4'd1;
    end
    return r;
  endfunction

endpackage : pyon_pkg
`default_nettype wire

// File: rtl/key_conditioner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | key_conditioner : synchronizer, optional debouncer and press detector     |
// | Build option: PYON_KEY_DEBOUNCE_EN enables the counter debouncer          |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module key_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic resetn,
  input  logic key_n,
  output logic level,
  output logic press
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q, prev_d;

  // Stored active-high so that the all-zero reset value means "released".
  assign sync1_d = ~key_n;
  assign sync2_d = sync1_q;

`ifdef PYON_KEY_DEBOUNCE_EN
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;

  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level = level_q;
`else
  logic unused_debounce;
  assign unused_debounce = (DEBOUNCE_CYCLES != 0);
  assign level = sync2_q;
`endif

  assign prev_d = level;
  assign press  = level & ~prev_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

endmodule : key_conditioner
`default_nettype wire

// File: rtl/player_judge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | player_judge : checks key presses against the next box, pulses shift,     |
// | counts remaining boxes in BCD and declares the winner.                    |
// | Build option: PYON_KEY_DEBOUNCE_EN debounces both keys                    |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module player_judge
  import pyon_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int PENALTY_CYCLES  = 25000000,
  parameter int START_TENS      = DEF_START_TENS,
  parameter int START_ONES      = DEF_START_ONES
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       enable,
  input  logic       left_n,
  input  logic       right_n,
  input  logic       box,
  input  logic       pc_ended,
  output logic       shift,
  output logic [3:0] score_ones,
  output logic [3:0] score_tens,
  output logic       penalty,
  output logic       finished,
  output logic [1:0] winner
);

  logic level_l, level_r;
  logic press_l, press_r;

  key_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_left (
    .clk    (clk),
    .resetn (resetn),
    .key_n  (left_n),
    .level  (level_l),
    .press  (press_l)
  );

  key_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_right (
    .clk    (clk),
    .resetn (resetn),
    .key_n  (right_n),
    .level  (level_r),
    .press  (press_r)
  );

  logic unused_levels;
  assign unused_levels = level_l ^ level_r;

  state_e      state_q, state_d;
  logic        shift_q, shift_d;
  logic        penalty_q, penalty_d;
  logic        finished_q, finished_d;
  logic [1:0]  winner_q, winner_d;
  logic [3:0]  tens_q, tens_d;
  logic [3:0]  ones_q, ones_d;
  logic [31:0] pen_cnt_q, pen_cnt_d;

  logic any_press;
  logic correct;

  assign any_press = press_l | press_r;
  assign correct   = (press_l ^ press_r) && (press_r == box);

  always_comb begin
    state_d   = state_q;
    shift_d   = 1'b0;
    winner_d  = winner_q;
    tens_d    = tens_q;
    ones_d    = ones_q;
    pen_cnt_d = pen_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_PLAY;
      end
      ST_PLAY: begin
        if (!enable) begin
          state_d   = ST_IDLE;
          pen_cnt_d = '0;
        end else if (correct) begin
          // A final correct press beats a simultaneous pc_ended.
          shift_d          = 1'b1;
          {tens_d, ones_d} = bcd_dec({tens_q, ones_q});
          if ({tens_q, ones_q} == 8'h01) begin
            state_d  = ST_DONE;
            winner_d = WIN_PLAYER;
          end else if (pc_ended) begin
            state_d  = ST_DONE;
            winner_d = WIN_PC;
          end
        end else if (pc_ended) begin
          state_d  = ST_DONE;
          winner_d = WIN_PC;
        end else if (any_press) begin
          state_d   = ST_PENALTY;
          pen_cnt_d = 32'(PENALTY_CYCLES - 1);
        end
      end
      ST_PENALTY: begin
        if (!enable) begin
          state_d   = ST_IDLE;
          pen_cnt_d = '0;
        end else if (pc_ended) begin
          state_d  = ST_DONE;
          winner_d = WIN_PC;
        end else if (pen_cnt_q == 32'd0) begin
          state_d = ST_PLAY;
        end else begin
          pen_cnt_d = pen_cnt_q - 32'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    penalty_d  = (state_d == ST_PENALTY);
    finished_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      shift_q    <= 1'b0;
      penalty_q  <= 1'b0;
      finished_q <= 1'b0;
      winner_q   <= WIN_NONE;
      tens_q     <= 4'(START_TENS);
      ones_q     <= 4'(START_ONES);
      pen_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      penalty_q  <= penalty_d;
      finished_q <= finished_d;
      winner_q   <= winner_d;
      tens_q     <= tens_d;
      ones_q     <= ones_d;
      pen_cnt_q  <= pen_cnt_d;
    end
  end

  assign shift      = shift_q;
  assign penalty    = penalty_q;
  assign finished   = finished_q;
  assign winner     = winner_q;
  assign score_tens = tens_q;
  assign score_ones = ones_q;

endmodule : player_judge
`default_nettype wire

// File: tb/tb_player_judge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_player_judge : randomized bench with a behavioural referee model       |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_player_judge;

  localparam int P = 8;
  localparam int N = 4;
`ifdef PYON_KEY_DEBOUNCE_EN
  localparam int LAT = N;
`else
  localparam int LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic       enable = 1'b0;
  logic       left_n = 1'b1;
  logic       right_n = 1'b1;
  logic       box = 1'b0;
  logic       pc_ended = 1'b0;
  logic       shift;
  logic [3:0] score_ones;
  logic [3:0] score_tens;
  logic       penalty;
  logic       finished;
  logic [1:0] winner;

  player_judge #(
    .DEBOUNCE_CYCLES(N),
    .PENALTY_CYCLES (P),
    .START_TENS     (3),
    .START_ONES     (2)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .enable     (enable),
    .left_n     (left_n),
    .right_n    (right_n),
    .box        (box),
    .pc_ended   (pc_ended),
    .shift      (shift),
    .score_ones (score_ones),
    .score_tens (score_tens),
    .penalty    (penalty),
    .finished   (finished),
    .winner     (winner)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // Behavioural model: key history as raw samples, game as plain integers.
  bit ml0, ml1, ml2, mr0, mr1, mr2;
  bit dl, dlp, dr, drp;
  int runl, runr;
  bit pl, pr, cor, anyp;
  bit m_run, m_lock, m_over, m_shift;
  int m_left, m_score, m_win;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ml0 = 0; ml1 = 0; ml2 = 0; mr0 = 0; mr1 = 0; mr2 = 0;
      dl = 0; dlp = 0; dr = 0; drp = 0; runl = 0; runr = 0;
      m_run = 0; m_lock = 0; m_over = 0; m_shift = 0;
      m_left = 0; m_score = 32; m_win = 0;
    end else begin
`ifdef PYON_KEY_DEBOUNCE_EN
      pl = dl && !dlp; dlp = dl;
      if (ml1 != dl) begin runl++; if (runl == N) begin dl = ml1; runl = 0; end end
      else runl = 0;
      pr = dr && !drp; drp = dr;
      if (mr1 != dr) begin runr++; if (runr == N) begin dr = mr1; runr = 0; end end
      else runr = 0;
`else
      pl = ml1 && !ml2;
      pr = mr1 && !mr2;
`endif
      ml2 = ml1; ml1 = ml0; ml0 = !left_n;
      mr2 = mr1; mr1 = mr0; mr0 = !right_n;

      m_shift = 0;
      cor  = (pl != pr) && (pr == box);
      anyp = pl || pr;
      if (m_over) begin
      end else if (m_lock) begin
        if (!enable) begin m_lock = 0; m_run = 0; m_left = 0; end
        else if (pc_ended) begin m_lock = 0; m_over = 1; m_win = 2; end
        else if (m_left == 0) m_lock = 0;
        else m_left--;
      end else if (m_run) begin
        if (!enable) m_run = 0;
        else if (cor) begin
          m_shift = 1;
          m_score--;
          if (m_score == 0) begin m_over = 1; m_win = 1; end
          else if (pc_ended) begin m_over = 1; m_win = 2; end
        end else if (pc_ended) begin m_over = 1; m_win = 2; end
        else if (anyp) begin m_lock = 1; m_left = P - 1; end
      end else if (enable) begin
        m_run = 1;
      end
    end
  end

  int shift_cnt = 0;
  int pen_run = 0;
  int last_pen_run = 0;
  int pen_entries = 0;
  bit pen_prev = 0;

  always @(negedge clk) begin
    chk("shift", 32'(shift), 32'(m_shift));
    chk("score_tens", 32'(score_tens), 32'(m_score / 10));
    chk("score_ones", 32'(score_ones), 32'(m_score % 10));
    chk("penalty", 32'(penalty), 32'(m_lock));
    chk("finished", 32'(finished), 32'(m_over));
    chk("winner", 32'(winner), 32'(m_win));
    if (shift === 1'b1) shift_cnt++;
    if (penalty === 1'b1 && !pen_prev) pen_entries++;
    if (penalty === 1'b1) pen_run++;
    else if (pen_run != 0) begin last_pen_run = pen_run; pen_run = 0; end
    pen_prev = (penalty === 1'b1);
  end

  task automatic step(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic press(input bit l, input bit r, input int hold, input int gap);
    left_n = !l; right_n = !r;
    step(hold);
    left_n = 1'b1; right_n = 1'b1;
    step(gap);
  endtask

  task automatic good(input bit b);
    box = b;
    press(!b, b, 2 + LAT, 3 + LAT);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    step(2);
    resetn = 1'b1;
    step(1);
  endtask

  task automatic wait_penalty(input string nm);
    bit found;
    found = 0;
    for (int i = 0; i < 30 + 2 * LAT && !found; i++) begin
      @(negedge clk);
      if (penalty === 1'b1) found = 1;
    end
    chk(nm, 32'(found), 32'd1);
    #1;
  endtask

  int sc0, pe0, hold, gap, act;

  initial begin
    #2 resetn = 1'b0;
    step(2);
    chk("reset_tens", 32'(score_tens), 32'd3);
    chk("reset_ones", 32'(score_ones), 32'd2);
    chk("reset_winner", 32'(winner), 32'd0);
    chk("reset_penalty", 32'(penalty), 32'd0);
    resetn = 1'b1;
    step(1);
    enable = 1'b1;
    step(2);

    // First correct press: shift exactly 3 edges after the key falls
    box = 1'b1; right_n = 1'b0;
    repeat (2 + LAT) @(negedge clk);
    chk("first_shift_early", 32'(shift), 32'd0);
    @(negedge clk);
    chk("first_shift", 32'(shift), 32'd1);
    #1 right_n = 1'b1;
    step(4 + LAT);
    chk("first_score", 32'({score_tens, score_ones}), 32'h31);
    chk("model_score_31", 32'(m_score), 32'd31);

    // Wrong key, press during lockout, press right after exit
    box = 1'b0; right_n = 1'b0;
    wait_penalty("wrong_enters_penalty");
    right_n = 1'b1;
    sc0 = shift_cnt;
    if (LAT == 0) begin
      left_n = 1'b0; step(1); left_n = 1'b1; step(P - 3);
    end else begin
      step(P - 2 - LAT);
    end
    left_n = 1'b0;
    repeat (2 + LAT) @(negedge clk);
    #1 chk("lockout_noshift", 32'(shift_cnt - sc0), 32'd0);
    @(negedge clk);
    chk("reentry_shift", 32'(shift), 32'd1);
    #1 left_n = 1'b1;
    step(4 + LAT);
    chk("pen_len", 32'(last_pen_run), 32'(P));
    chk("reentry_score", 32'({score_tens, score_ones}), 32'h30);

    // Both keys together
    sc0 = shift_cnt; pe0 = pen_entries;
    box = 1'b0;
    press(1, 1, 2 + LAT, P + 6 + 2 * LAT);
    chk("both_penalty", 32'(pen_entries - pe0), 32'd1);
    chk("both_noshift", 32'(shift_cnt - sc0), 32'd0);

    // Tie on the final box
    do_reset();
    enable = 1'b1;
    step(2);
    for (int i = 0; i < 31; i++) good(1'($urandom % 2));
    chk("tie_pre_score", 32'({score_tens, score_ones}), 32'h01);
    box = 1'b0; left_n = 1'b0;
    repeat (2 + LAT) @(negedge clk);
    #1 pc_ended = 1'b1;
    @(negedge clk);
    chk("tie_shift", 32'(shift), 32'd1);
    #1 pc_ended = 1'b0; left_n = 1'b1;
    step(3 + LAT);
    chk("tie_winner", 32'(winner), 32'd1);
    chk("tie_finished", 32'(finished), 32'd1);
    chk("tie_score", 32'({score_tens, score_ones}), 32'h00);
    sc0 = shift_cnt;
    good(0); good(1);
    chk("done_noshift", 32'(shift_cnt - sc0), 32'd0);

    // PC finishes first at score 15
    do_reset();
    enable = 1'b1;
    step(2);
    for (int i = 0; i < 17; i++) good(1'($urandom % 2));
    chk("pc_pre_score", 32'({score_tens, score_ones}), 32'h15);
    pc_ended = 1'b1; step(1); pc_ended = 1'b0;
    step(2);
    chk("pc_winner", 32'(winner), 32'd2);
    chk("pc_finished", 32'(finished), 32'd1);
    sc0 = shift_cnt;
    good(0); good(1);
    chk("pc_frozen", 32'({score_tens, score_ones}), 32'h15);
    chk("pc_noshift", 32'(shift_cnt - sc0), 32'd0);

    // Asynchronous reset in the middle of a lockout
    do_reset();
    enable = 1'b1;
    step(2);
    box = 1'b1; left_n = 1'b0;
    wait_penalty("async_pen_enter");
    left_n = 1'b1;
    step(2);
    #2 resetn = 1'b0;
    #1;
    chk("async_penalty", 32'(penalty), 32'd0);
    chk("async_score", 32'({score_tens, score_ones}), 32'h32);
    chk("async_finished", 32'(finished), 32'd0);
    step(1);
    resetn = 1'b1;
    step(1);

    // Randomized play
    for (int t = 0; t < 300; t++) begin
      if (m_over || ($urandom % 40) == 0) do_reset();
      enable = (($urandom % 25) != 0);
      if (($urandom % 30) == 0) begin pc_ended = 1'b1; step(1); pc_ended = 1'b0; end
      box  = 1'($urandom % 2);
      hold = $urandom_range(1, 3 + 2 * LAT);
      gap  = $urandom_range(0, 3 + LAT);
      act  = $urandom % 8;
      case (act)
        0, 1, 2, 3: press(!box, box, hold, gap);
        4:          press(box, !box, hold, gap);
        5:          press(1, 1, hold, gap);
        6:          step(hold + gap);
        default:    press(1'($urandom % 2), 1'($urandom % 2), hold, gap);
      endcase
    end
    step(6 + 2 * LAT);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_player_judge
`default_nettype wire
